// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller and the PC mux.
package pipeline_hazard_controller_pkg;

    localparam int unsigned PC_SRC_W = 2;
    localparam int unsigned REG_W    = 5;

    localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Bundle of pipeline-register controls driven every cycle.
    typedef struct packed {
        logic                pc_write;
        logic                ifid_write;
        logic                idex_write;
        logic                exmem_write;
        logic                ifid_flush;
        logic                idex_flush;
        logic                exmem_flush;
        logic                memwb_bubble;
        logic [PC_SRC_W-1:0] pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF  = '{default: '0};
    localparam ctrl_t CTRL_FLOW = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                    exmem_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
                                    exmem_flush: 1'b0, memwb_bubble: 1'b0, pc_src: PC_SRC_SEQ};

    // A jump outranks a branch when both are flagged in EX/MEM.
    function automatic logic [PC_SRC_W-1:0] redirect_src(input logic jump);
        return jump ? PC_SRC_JUMP : PC_SRC_BRANCH;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count on the falling edge alongside the pipeline registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/redirect sequencing for the 5-stage MIPS pipeline.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_zero,
    input  logic             exmem_beq,
    input  logic             exmem_bne,
    input  logic             exmem_jump,
    input  logic             exmem_mem_read,
    input  logic             exmem_mem_write,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic [1:0]       pc_src,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              err_set;
    logic              stall_inc;
    logic              flush_inc;
    logic              freeze;
    logic              load_use;
    logic              take;
    logic              mem_busy;
    logic              timeout;
    ctrl_t             ctrl;

    // Hazard and redirect detection terms.
    always_comb begin
        load_use = idex_mem_read && (idex_rt != REG_W'(0))
                   && ((idex_rt == id_rs) || (idex_rt == id_rt));
        take     = (exmem_beq && exmem_zero) || (exmem_bne && !exmem_zero) || exmem_jump;
        mem_busy = (exmem_mem_read || exmem_mem_write) && !mem_ready;
        timeout  = (wait_cnt == WAIT_W'(MEM_TIMEOUT));
    end

    // Next-state, wait counter and control decode; freeze > redirect > load-use.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        freeze    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        ctrl      = CTRL_FLOW;

        case (state)
            RUN: begin
                if (mem_busy) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (timeout) begin
                    err_set   = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        if (freeze) begin
            // EX/MEM is held, so any pending redirect waits for release.
            ctrl.pc_write     = 1'b0;
            ctrl.ifid_write   = 1'b0;
            ctrl.idex_write   = 1'b0;
            ctrl.exmem_write  = 1'b0;
            ctrl.memwb_bubble = 1'b1;
            stall_inc         = 1'b1;
        end else if (take) begin
            // The dependent instruction is flushed, so load-use is moot.
            ctrl.pc_src      = redirect_src(exmem_jump);
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            flush_inc        = 1'b1;
        end else if (load_use) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
            stall_inc       = 1'b1;
        end

        if (!reset) begin
            ctrl      = CTRL_OFF;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
            err_set   = 1'b0;
        end
    end

    // Drive the control ports from the decoded bundle.
    always_comb begin
        pc_write     = ctrl.pc_write;
        ifid_write   = ctrl.ifid_write;
        idex_write   = ctrl.idex_write;
        exmem_write  = ctrl.exmem_write;
        ifid_flush   = ctrl.ifid_flush;
        idex_flush   = ctrl.idex_flush;
        exmem_flush  = ctrl.exmem_flush;
        memwb_bubble = ctrl.memwb_bubble;
        pc_src       = ctrl.pc_src;
    end

    // State, wait counter and sticky timeout flag on the falling edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set) begin
                mem_error <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (short timeout, narrow counters).
module tb_pipeline_hazard_controller;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 4;

    // {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, bubble, pc_src}
    localparam logic [9:0] C_OFF  = 10'b0000_0000_00;
    localparam logic [9:0] C_IDLE = 10'b1111_0000_00;
    localparam logic [9:0] C_LU   = 10'b0011_0100_00;
    localparam logic [9:0] C_BR   = 10'b1111_1110_01;
    localparam logic [9:0] C_JMP  = 10'b1111_1110_10;
    localparam logic [9:0] C_FRZ  = 10'b0000_0001_00;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic             exmem_zero;
    logic             exmem_beq;
    logic             exmem_bne;
    logic             exmem_jump;
    logic             exmem_mem_read;
    logic             exmem_mem_write;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic [1:0]       pc_src;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [9:0]       ctl;

    int compared   = 0;
    int mismatched = 0;

    pipeline_hazard_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .idex_mem_read   (idex_mem_read),
        .idex_rt         (idex_rt),
        .exmem_zero      (exmem_zero),
        .exmem_beq       (exmem_beq),
        .exmem_bne       (exmem_bne),
        .exmem_jump      (exmem_jump),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_mem_write (exmem_mem_write),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .memwb_bubble    (memwb_bubble),
        .pc_src          (pc_src),
        .mem_error       (mem_error),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    assign ctl = {pc_write, ifid_write, idex_write, exmem_write,
                  ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_src};

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next falling edge, leaving time to drive then sample.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs           = '0;
        id_rt           = '0;
        idex_mem_read   = 1'b0;
        idex_rt         = '0;
        exmem_zero      = 1'b0;
        exmem_beq       = 1'b0;
        exmem_bne       = 1'b0;
        exmem_jump      = 1'b0;
        exmem_mem_read  = 1'b0;
        exmem_mem_write = 1'b0;
        mem_ready       = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] id_t);
        idex_mem_read = 1'b1;
        idex_rt       = rt;
        id_rs         = rs;
        id_rt         = id_t;
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        #2;
        chk("rst_ctl", 32'(ctl), 32'(C_OFF));
        chk("rst_stall", 32'(stall_count), 0);
        chk("rst_flush", 32'(flush_count), 0);
        chk("rst_err", 32'(mem_error), 0);
        #1 reset = 1'b1;
        #1;
        chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

        // load-use via rs
        next_cycle(); set_load_use(5'd8, 5'd8, 5'd0); #1;
        chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
        next_cycle(); clear_in(); #1;
        chk("lu_rs_after", 32'(ctl), 32'(C_IDLE));
        chk("lu_rs_stall", 32'(stall_count), 1);

        // load into $zero never stalls
        next_cycle(); set_load_use(5'd0, 5'd0, 5'd0); #1;
        chk("lu_r0_ctl", 32'(ctl), 32'(C_IDLE));
        next_cycle(); clear_in(); #1;
        chk("lu_r0_stall", 32'(stall_count), 1);

        // load-use via rt, then a non-matching load
        next_cycle(); set_load_use(5'd5, 5'd3, 5'd5); #1;
        chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
        next_cycle(); set_load_use(5'd7, 5'd1, 5'd2); #1;
        chk("lu_nomatch_ctl", 32'(ctl), 32'(C_IDLE));
        chk("lu_rt_stall", 32'(stall_count), 2);

        // bne taken / not taken, beq taken, jump beats beq
        next_cycle(); clear_in(); exmem_bne = 1'b1; exmem_zero = 1'b0; #1;
        chk("bne_t_ctl", 32'(ctl), 32'(C_BR));
        next_cycle(); exmem_zero = 1'b1; #1;
        chk("bne_nt_ctl", 32'(ctl), 32'(C_IDLE));
        chk("bne_flush", 32'(flush_count), 1);
        next_cycle(); clear_in(); exmem_beq = 1'b1; exmem_zero = 1'b1; #1;
        chk("beq_t_ctl", 32'(ctl), 32'(C_BR));
        next_cycle(); exmem_jump = 1'b1; #1;
        chk("jmp_ctl", 32'(ctl), 32'(C_JMP));
        chk("beq_flush", 32'(flush_count), 2);

        // redirect plus load-use: only the flush
        next_cycle(); clear_in(); exmem_bne = 1'b1; set_load_use(5'd8, 5'd8, 5'd0); #1;
        chk("take_lu_ctl", 32'(ctl), 32'(C_BR));
        chk("take_lu_flush_pre", 32'(flush_count), 3);
        next_cycle(); clear_in(); #1;
        chk("take_lu_stall", 32'(stall_count), 2);
        chk("take_lu_flush", 32'(flush_count), 4);

        // memory wait, 3 frozen cycles with a taken beq held behind it
        next_cycle(); exmem_mem_read = 1'b1; mem_ready = 1'b0;
        exmem_beq = 1'b1; exmem_zero = 1'b1; #1;
        chk("mw_frz0", 32'(ctl), 32'(C_FRZ));
        next_cycle(); #1;
        chk("mw_frz1", 32'(ctl), 32'(C_FRZ));
        next_cycle(); #1;
        chk("mw_frz2", 32'(ctl), 32'(C_FRZ));
        chk("mw_flush_held", 32'(flush_count), 4);
        next_cycle(); mem_ready = 1'b1; #1;
        chk("mw_release", 32'(ctl), 32'(C_BR));
        chk("mw_stall", 32'(stall_count), 5);
        next_cycle(); clear_in(); mem_ready = 1'b0; #1;
        chk("mw_back_run", 32'(ctl), 32'(C_IDLE));
        chk("mw_flush", 32'(flush_count), 5);
        chk("mw_err", 32'(mem_error), 0);

        // timeout: mem_ready never comes
        next_cycle(); exmem_mem_write = 1'b1; mem_ready = 1'b0; #1;
        chk("to_frz0", 32'(ctl), 32'(C_FRZ));
        for (int i = 1; i <= 3; i++) begin
            next_cycle(); #1;
            chk($sformatf("to_frz%0d", i), 32'(ctl), 32'(C_FRZ));
        end
        next_cycle(); #1;
        chk("to_release", 32'(ctl), 32'(C_IDLE));
        chk("to_err_pre", 32'(mem_error), 0);
        chk("to_stall", 32'(stall_count), 9);
        next_cycle(); clear_in(); mem_ready = 1'b0; #1;
        chk("to_err_set", 32'(mem_error), 1);
        chk("to_back_run", 32'(ctl), 32'(C_IDLE));
        next_cycle(); mem_ready = 1'b1; #1;
        chk("to_err_sticky", 32'(mem_error), 1);

        // stall counter saturates
        for (int i = 0; i < 8; i++) begin
            next_cycle(); set_load_use(5'd9, 5'd9, 5'd0); #1;
            chk("sat_lu_ctl", 32'(ctl), 32'(C_LU));
        end
        next_cycle(); clear_in(); #1;
        chk("sat_stall", 32'(stall_count), 15);
        next_cycle(); #1;
        chk("sat_stall_hold", 32'(stall_count), 15);

        // flush counter saturates
        exmem_bne = 1'b1;
        for (int i = 0; i < 12; i++) begin
            next_cycle(); #1;
        end
        next_cycle(); clear_in(); #1;
        chk("sat_flush", 32'(flush_count), 15);

        // reset mid-flush
        next_cycle(); exmem_jump = 1'b1; #1;
        chk("rf_pre", 32'(ctl), 32'(C_JMP));
        reset = 1'b0; #1;
        chk("rf_ctl", 32'(ctl), 32'(C_OFF));
        chk("rf_flush", 32'(flush_count), 0);
        chk("rf_stall", 32'(stall_count), 0);
        chk("rf_err", 32'(mem_error), 0);
        reset = 1'b1; clear_in();

        // reset mid-wait
        next_cycle(); exmem_mem_read = 1'b1; mem_ready = 1'b0; #1;
        chk("rw_frz0", 32'(ctl), 32'(C_FRZ));
        next_cycle(); #1;
        chk("rw_frz1", 32'(ctl), 32'(C_FRZ));
        chk("rw_stall_pre", 32'(stall_count), 1);
        reset = 1'b0; #1;
        chk("rw_ctl", 32'(ctl), 32'(C_OFF));
        chk("rw_stall", 32'(stall_count), 0);
        reset = 1'b1; exmem_mem_read = 1'b0; #1;
        chk("rw_run", 32'(ctl), 32'(C_IDLE));
        next_cycle(); #1;
        chk("rw_run_next", 32'(ctl), 32'(C_IDLE));
        chk("rw_stall_next", 32'(stall_count), 0);
        chk("rw_err", 32'(mem_error), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
